multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  FSM that sequences the datapath one RISC-V RV32I instruction at a time over several cycles.
//  Instruction fetch and load/store share one memory port; that memory signals completion with mem_ready after variable latency.
//  Drives the strobes for PC, IR, register file, memory, ALU and the operand/writeback muxes.
//  Flags illegal opcodes and memory timeouts, and counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles spent waiting for mem_ready in FETCH/MEM before FAULT (>=2)
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk          in   1      single clock, all state updates on rising edge
//  reset        in   1      synchronous, active-low: reset==0 at a rising edge resets the block
//  run          in   1      1 = keep issuing instructions; sampled only in IDLE and at retire
//  opcode       in   7      IR[6:0] of the current instruction
//  alu_zero     in   1      ALU zero flag (branch-taken condition)
//  mem_ready    in   1      memory completes current read/write this cycle
//  mem_read     out  1      memory read strobe
//  mem_write    out  1      memory write strobe
//  iord         out  1      1 = memory address from PC (fetch), 0 = from ALU result
//  ir_write     out  1      latch memory read data into IR
//  pc_write     out  1      update PC this cycle
//  pc_src       out  1      1 = branch target, 0 = PC+4 (valid with pc_write)
//  reg_write    out  1      register-file write enable
//  mem_to_reg   out  1      writeback source: 1 = memory read data, 0 = ALU
//  alu_src      out  1      1 = immediate operand B, 0 = register
//  alu_op1      out  1      with alu_op0: 00 add, 01 sub, 10 R-type funct, 11 I-type funct
//  alu_op0      out  1
//  busy         out  1      state != IDLE and state != FAULT
//  fault        out  1      sticky: illegal opcode or memory timeout
//  instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset: state=IDLE, instret=0, wait counter=0, fault=0. All outputs 0 in IDLE.
//  Outputs are combinational from the registered state and opcode. Only ir_write and MEM-state pc_write also depend on mem_ready.
//  Legal opcodes:
//   R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011. Anything else is illegal.
//  States and transitions:
//   IDLE:   run=1 -> FETCH.
//   FETCH:  mem_read=1, iord=1. On mem_ready: ir_write=1, go to DECODE.
//   DECODE: illegal opcode -> FAULT. Otherwise -> EXEC. No strobes.
//   EXEC:   R: alu_op=10, alu_src=0, go to WB.
//           I-ALU: alu_op=11, alu_src=1, go to WB.
//           LOAD/STORE: alu_op=00, alu_src=1, go to MEM.
//           BRANCH: alu_op=01, alu_src=0, pc_write=1, pc_src=alu_zero, retire.
//   MEM:    iord=0, alu_op=00, alu_src=1.
//           LOAD: mem_read=1 until mem_ready, then WB.
//           STORE: mem_write=1 until mem_ready; on mem_ready pc_write=1, pc_src=0, retire.
//   WB:     reg_write=1, mem_to_reg=(LOAD), pc_write=1, pc_src=0, retire.
//   FAULT:  fault=1, no strobes. Exits only via reset.
//  Retire: instret increments by 1 (wraps 2^CNT_W-1 -> 0). Next state = FETCH if run=1, else IDLE.
//  Timeout: the wait counter clears on entry to FETCH/MEM and increments each cycle without mem_ready.
//   With no mem_ready after MEM_TIMEOUT cycles in that state -> FAULT (strobes drop next cycle).
//   mem_ready on the final allowed cycle wins over timeout.
//  mem_ready outside FETCH/MEM is ignored.
//  run=0 mid-instruction: the instruction completes and retires, then IDLE.
//  reset low in any state, including mid-handshake: next edge IDLE, all strobes 0, counters cleared.
//   A partial memory access is abandoned (memory must tolerate a dropped strobe).
//  Exactly one of mem_read/mem_write at a time; reg_write and mem_write are never both 1.
// STRUCTURE
//  cpu_pkg: opcode localparams, state encoding (3-bit), ALU-op codes.
//  Sub-module opcode_classify (combinational): opcode -> {is_r, is_i, is_load, is_store, is_branch, illegal}.
//  Top holds the state register, wait counter and instret counter.
// TESTING
//  1 R-type, mem_ready at 1st FETCH cycle -> FETCH, DECODE, EXEC, WB.
//    reg_write=1 in WB, instret=1, 4 cycles per instruction.
//  2 LOAD with mem_ready delayed 3 cycles in FETCH and in MEM.
//    mem_read held 4 cycles each time, then WB with mem_to_reg=1. Total 11 cycles.
//  3 BRANCH with alu_zero=1 -> pc_write=1, pc_src=1 in EXEC, no reg_write.
//    With alu_zero=0 -> pc_src=0.
//  4 opcode 7'b1111111 -> FAULT after DECODE, fault=1 persists, busy=0.
//    reset low 1 cycle -> IDLE, fault=0.
//  5 STORE, mem_ready never asserted, MEM_TIMEOUT=16 -> 16 cycles of mem_write=1, then FAULT.
//    Repeat with mem_ready on 16th cycle -> retire, no fault.
//  6 run dropped during MEM -> instruction retires, IDLE. reset low during FETCH -> IDLE next edge, instret=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Opcode, state and ALU-op encodings for the multicycle control FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i      = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  localparam logic [1:0] c_alu_add   = 2'b00;
  localparam logic [1:0] c_alu_sub   = 2'b01;
  localparam logic [1:0] c_alu_rtype = 2'b10;
  localparam logic [1:0] c_alu_itype = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  typedef struct packed {
    logic is_r;
    logic is_i;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic illegal;
  } op_class_t;

endpackage

`default_nettype wire

// File: rtl/opcode_classify.sv
// ============================================================================
// Module  : opcode_classify
// Brief   : Combinational RV32I opcode decoder into instruction-class flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module opcode_classify
  import cpu_pkg::*;
(
  input  logic [6:0] i_opcode,
  output op_class_t  o_class
);

  always_comb begin
    o_class           = '0;
    o_class.is_r      = (i_opcode == c_op_r);
    o_class.is_i      = (i_opcode == c_op_i);
    o_class.is_load   = (i_opcode == c_op_load);
    o_class.is_store  = (i_opcode == c_op_store);
    o_class.is_branch = (i_opcode == c_op_branch);
    o_class.illegal   = !(o_class.is_r || o_class.is_i || o_class.is_load ||
                          o_class.is_store || o_class.is_branch);
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module  : multicycle_control
// Brief   : Multicycle RV32I control FSM with shared memory port, timeout
//           fault detection and retired-instruction counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             alu_op1,
  output logic             alu_op0,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  localparam int                  c_wait_w    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MEM_TIMEOUT - 1);

  state_t              r_state;
  logic [c_wait_w-1:0] r_wait;
  logic [CNT_W-1:0]    r_instret;
  op_class_t           w_cls;
  logic                w_retire;
  logic                w_timeout;
  logic [1:0]          w_alu_op;

  opcode_classify u_classify (
    .i_opcode (opcode),
    .o_class  (w_cls)
  );

  assign w_timeout = !mem_ready && (r_wait == c_wait_last);
  assign w_retire  = (r_state == ST_WB) ||
                     (r_state == ST_EXEC && w_cls.is_branch) ||
                     (r_state == ST_MEM  && w_cls.is_store && mem_ready);

  // The wait counter is zero in every state except while stalled in FETCH/MEM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      r_wait <= '0;
      if (w_retire)
        r_instret <= r_instret + 1'b1;
      case (r_state)
        ST_IDLE: if (run) r_state <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ready)      r_state <= ST_DECODE;
          else if (w_timeout) r_state <= ST_FAULT;
          else                r_wait  <= r_wait + 1'b1;
        end
        ST_DECODE: r_state <= w_cls.illegal ? ST_FAULT : ST_EXEC;
        ST_EXEC: begin
          if (w_cls.is_r || w_cls.is_i)             r_state <= ST_WB;
          else if (w_cls.is_load || w_cls.is_store) r_state <= ST_MEM;
          else if (w_cls.is_branch)                 r_state <= run ? ST_FETCH : ST_IDLE;
          else                                      r_state <= ST_FAULT;
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (w_cls.is_load)       r_state <= ST_WB;
            else if (w_cls.is_store) r_state <= run ? ST_FETCH : ST_IDLE;
            else                     r_state <= ST_FAULT;
          end else if (w_timeout) begin
            r_state <= ST_FAULT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        ST_WB:    r_state <= run ? ST_FETCH : ST_IDLE;
        ST_FAULT: r_state <= ST_FAULT;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    w_alu_op   = c_alu_add;
    case (r_state)
      ST_FETCH: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        ir_write = mem_ready;
      end
      ST_EXEC: begin
        if (w_cls.is_r) begin
          w_alu_op = c_alu_rtype;
        end else if (w_cls.is_i) begin
          w_alu_op = c_alu_itype;
          alu_src  = 1'b1;
        end else if (w_cls.is_load || w_cls.is_store) begin
          alu_src  = 1'b1;
        end else if (w_cls.is_branch) begin
          w_alu_op = c_alu_sub;
          pc_write = 1'b1;
          pc_src   = alu_zero;
        end
      end
      ST_MEM: begin
        alu_src   = 1'b1;
        mem_read  = w_cls.is_load;
        mem_write = w_cls.is_store;
        pc_write  = w_cls.is_store && mem_ready;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = w_cls.is_load;
        pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_op1 = w_alu_op[1];
  assign alu_op0 = w_alu_op[0];
  assign busy    = (r_state != ST_IDLE) && (r_state != ST_FAULT);
  assign fault   = (r_state == ST_FAULT);
  assign instret = r_instret;

endmodule

`default_nettype wire
